// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, opcode constants and fetch state encoding.
package mips_pkg;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int JADDR_MSB = 25;
    localparam int JADDR_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit MIPS instruction word into its decode fields.
module instr_field_split
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] jaddr
);

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign rs     = ir[RS_MSB:RS_LSB];
    assign rt     = ir[RT_MSB:RT_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign shamt  = ir[SHAMT_MSB:SHAMT_LSB];
    assign funct  = ir[FUNCT_MSB:FUNCT_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];
    assign jaddr  = ir[JADDR_MSB:JADDR_LSB];

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack fetch, instruction register and redirect handling.
// Optional FETCH_COUNT_EN adds a fetch_count output counting consumed instructions.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_vld,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_plus4,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [25:0]       jaddr,
    output logic [1:0]        fetch_state
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    if (DATA_W != 32) begin : g_bad_width
        $error("instr_fetch_stage: DATA_W must be 32");
    end

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_HOLD = HOLD;

    // Handshakes: imem_req stays high with imem_addr stable until a cycle with imem_ack
    // (or a redirect); instr_valid stays high with IR stable until a cycle with dec_ready.
    logic [1:0]        state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] target_pc;

    assign target_pc = redirect_pc & ~32'd3;

    // Redirect beats ack and dec_ready: a same-cycle ack is dropped, a held IR is squashed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (redirect_vld) begin
                        pc <= target_pc;
                    end else if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_vld) begin
                        pc    <= target_pc;
                        state <= S_REQ;
                    end else if (dec_ready) begin
                        pc    <= pc + PC_INCR;
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (state == S_HOLD && dec_ready && !redirect_vld) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_HOLD);
    assign pc_out      = pc;
    assign pc_plus4    = pc + PC_INCR;
    assign fetch_state = state;

    instr_field_split u_split (
        .ir     (ir),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm    (imm),
        .jaddr  (jaddr)
    );

endmodule
